// File: rtl/round_key_reverse_buffer_if.sv
// -----------------------------------------------------------------------------
// round_key_reverse_buffer_if
//   Handshake bundle between the forward key expansion (writer), the decrypt
//   datapath (reader) and the round key reverse buffer.
//   Signals:
//     flush   - synchronous abort, back to FILL
//     replay  - restart reverse readout from DONE
//     wrValid/wrKey/wrReady          - write channel (keys in round order 0..N-1)
//     rdValid/rdKey/rdRound/rdReady  - read channel (keys in order N-1..0)
//     done    - all keys consumed, keys retained for replay
//   Modports: master = controller/datapath side, slave = buffer side.
// -----------------------------------------------------------------------------
interface round_key_reverse_buffer_if #(
    parameter int KEY_W = 128
);
    logic             flush;
    logic             replay;
    logic             wrValid;
    logic [KEY_W-1:0] wrKey;
    logic             wrReady;
    logic             rdValid;
    logic [KEY_W-1:0] rdKey;
    logic [3:0]       rdRound;
    logic             rdReady;
    logic             done;

    modport master (
        output flush, replay, wrValid, wrKey, rdReady,
        input  wrReady, rdValid, rdKey, rdRound, done
    );

    modport slave (
        input  flush, replay, wrValid, wrKey, rdReady,
        output wrReady, rdValid, rdKey, rdRound, done
    );
endinterface

// File: rtl/round_key_reverse_buffer.sv
// -----------------------------------------------------------------------------
// round_key_reverse_buffer
//   Stores NKEYS round keys written in forward order by the key expansion and
//   hands them back in reverse order (NKEYS-1 down to 0) for AES decryption.
//   Three states: FILL (accept writes), DRAIN (present keys), DONE (keys held,
//   replay restarts the readout).
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - round_key_reverse_buffer_if.slave (handshakes, flush, replay, done)
//   All outputs come straight from flops; rdKey/rdRound are zero whenever
//   rdValid is low.
// -----------------------------------------------------------------------------
module round_key_reverse_buffer #(
    parameter int KEY_W = 128,
    parameter int NKEYS = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    round_key_reverse_buffer_if.slave     bus
);

    localparam int IDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NKEYS - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   wridx_q, wridx_d;
    logic [IDX_W-1:0]   rdidx_q, rdidx_d;
    logic [KEY_W-1:0]   slot_q [NKEYS];
    logic [KEY_W-1:0]   slot_d [NKEYS];

    logic               wrready_q, wrready_d;
    logic               rdvalid_q, rdvalid_d;
    logic               done_q,    done_d;
    logic [KEY_W-1:0]   rdkey_q,   rdkey_d;
    logic [3:0]         rdround_q, rdround_d;

    // Next-state, index and slot update logic; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        wridx_d = wridx_q;
        rdidx_d = rdidx_q;
        slot_d  = slot_q;

        if (bus.flush) begin
            state_d = ST_FILL;
            wridx_d = ZERO_IDX;
            rdidx_d = ZERO_IDX;
            for (int i = 0; i < NKEYS; i++) begin
                slot_d[i] = {KEY_W{1'b0}};
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (bus.wrValid) begin
                        slot_d[wridx_q] = bus.wrKey;
                        if (wridx_q == LAST_IDX) begin
                            state_d = ST_DRAIN;
                            wridx_d = ZERO_IDX;
                            rdidx_d = LAST_IDX;
                        end else begin
                            wridx_d = wridx_q + ONE_IDX;
                        end
                    end else begin
                        wridx_d = wridx_q;
                    end
                end
                ST_DRAIN: begin
                    if (bus.rdReady) begin
                        // Round 0 is the last key; stop rather than wrap.
                        if (rdidx_q == ZERO_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            rdidx_d = rdidx_q - ONE_IDX;
                        end
                    end else begin
                        rdidx_d = rdidx_q;
                    end
                end
                ST_DONE: begin
                    if (bus.replay) begin
                        state_d = ST_DRAIN;
                        rdidx_d = LAST_IDX;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    wridx_d = ZERO_IDX;
                    rdidx_d = ZERO_IDX;
                end
            endcase
        end
    end

    // Output decode from the next state so every output is a flop; the key of
    // the final write reaches rdKey one cycle after it is accepted.
    always_comb begin
        wrready_d = (state_d == ST_FILL);
        rdvalid_d = (state_d == ST_DRAIN);
        done_d    = (state_d == ST_DONE);
        if (state_d == ST_DRAIN) begin
            rdkey_d   = slot_d[rdidx_d];
            rdround_d = 4'(rdidx_d);
        end else begin
            rdkey_d   = {KEY_W{1'b0}};
            rdround_d = 4'd0;
        end
    end

    // State, indices, slot storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FILL;
            wridx_q   <= ZERO_IDX;
            rdidx_q   <= ZERO_IDX;
            for (int i = 0; i < NKEYS; i++) begin
                slot_q[i] <= {KEY_W{1'b0}};
            end
            wrready_q <= 1'b1;
            rdvalid_q <= 1'b0;
            done_q    <= 1'b0;
            rdkey_q   <= {KEY_W{1'b0}};
            rdround_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            wridx_q   <= wridx_d;
            rdidx_q   <= rdidx_d;
            for (int i = 0; i < NKEYS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            wrready_q <= wrready_d;
            rdvalid_q <= rdvalid_d;
            done_q    <= done_d;
            rdkey_q   <= rdkey_d;
            rdround_q <= rdround_d;
        end
    end

    assign bus.wrReady = wrready_q;
    assign bus.rdValid = rdvalid_q;
    assign bus.done    = done_q;
    assign bus.rdKey   = rdkey_q;
    assign bus.rdRound = rdround_q;

endmodule

// File: doc/round_key_reverse_buffer.md
ROUND_KEY_REVERSE_BUFFER -- requirements
Module: round_key_reverse_buffer

Interface
REQ-001 Parameter KEY_W, default 128, round key width in bits.
REQ-002 Parameter NKEYS, default 11, number of round keys stored (AES-128 rounds 0..10).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  synchronous abort; discards contents and returns to FILL.
REQ-006 replay  input  1  restarts reverse readout of stored keys without rewriting them.
REQ-007 wrValid  input  1  writer presents a round key.
REQ-008 wrKey  input  KEY_W  round key from forward key expansion, in round order 0..NKEYS-1.
REQ-009 wrReady  output  1  buffer accepts a key this cycle.
REQ-010 rdValid  output  1  rdKey/rdRound valid for the decrypt datapath.
REQ-011 rdKey  output  KEY_W  round key for the decrypt AddRoundKey stage.
REQ-012 rdRound  output  4  round number of rdKey.
REQ-013 rdReady  input  1  decrypt datapath consumes rdKey this cycle.
REQ-014 done  output  1  all NKEYS keys consumed; buffer holds keys for replay.

Function
REQ-015 The block SHALL have three states: FILL, DRAIN, DONE.
REQ-016 FILL: wrReady=1, rdValid=0, done=0; a write is accepted when wrValid&&wrReady and is stored at slot wrIdx; wrIdx increments.
REQ-017 The accept of slot NKEYS-1 SHALL move the block to DRAIN next cycle with rdIdx=NKEYS-1; wrIdx returns to 0.
REQ-018 DRAIN: wrReady=0, rdValid=1, rdKey=slot[rdIdx], rdRound=rdIdx; both SHALL be stable while rdValid&&!rdReady.
REQ-019 A read is consumed when rdValid&&rdReady; rdIdx decrements; consuming rdIdx=0 SHALL move the block to DONE next cycle (no wrap to NKEYS-1).
REQ-020 Keys SHALL be presented in order NKEYS-1 down to 0, one per consumed cycle, zero-bubble under continuous rdReady.
REQ-021 DONE: wrReady=0, rdValid=0, done=1; stored keys retained.
REQ-022 replay in DONE SHALL move to DRAIN with rdIdx=NKEYS-1; replay in FILL or DRAIN SHALL be ignored.
REQ-023 flush in any state SHALL move to FILL with wrIdx=0 and rdIdx=0, and SHALL take priority over replay, writes and reads in the same cycle (that cycle's handshake is not counted).
REQ-024 wrValid asserted outside FILL SHALL be ignored; rdReady asserted outside DRAIN SHALL be ignored.
REQ-025 Latency: first key visible on rdKey one cycle after the final write is accepted.
REQ-026 rdKey SHALL be driven all-zero whenever rdValid=0.
REQ-027 Slot storage SHALL be registers; no data path between wrKey and rdKey in the same cycle.

Reset
REQ-028 While rst=1 and after release: state=FILL, wrIdx=0, rdIdx=0, all slots zero, wrReady=1, rdValid=0, rdKey=0, rdRound=0, done=0.
REQ-029 rst asserted mid-FILL or mid-DRAIN SHALL abort immediately; partial contents discarded.

Verification
REQ-030 Write FIPS-197 key expansion of 2b7e151628aed2a6abf7158809cf4f3c (rounds 0..10), rdReady=1 -> next cycle rdRound=10, rdKey=d014f9a8c9ee2589e13f0cc8b6630ca6; then rounds 9..0 on consecutive cycles, last rdKey=2b7e1516...4f3c; done=1 cycle after.
REQ-031 Same fill, rdReady toggled 1,0,0,1 -> rdKey/rdRound hold during stall; sequence 10,9,8... unchanged, no key skipped or duplicated.
REQ-032 After DONE pulse replay=1 -> rdRound=10 with same key as REQ-030; wrValid=1 with new data meanwhile -> ignored, wrReady=0.
REQ-033 Write 5 keys, assert flush together with wrValid=1 -> that key not stored, wrReady=1, next 11 writes required before rdValid=1.
REQ-034 Assert rst during DRAIN at rdRound=6 -> rdValid=0, wrReady=1, rdKey=0 immediately; full refill required.
REQ-035 wrValid held high with back-to-back keys 11 cycles -> all accepted, wrReady=0 on 12th cycle, rdValid=1.
